// File: rtl/mesh_lock_sequencer_pkg.sv
// Shared types for the mesh lock sequencer: FSM/mode encodings, weight constants
// and the per-node coupling weight table.
package mesh_lock_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAIL   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_PLL     = 2'd0,
    MODE_UNI     = 2'd1,
    MODE_NET     = 2'd2,
    MODE_NET_ALT = 2'd3
  } mode_e;

  localparam logic [2:0] W0 = 3'd0;
  localparam logic [2:0] W1 = 3'd1;
  localparam logic [2:0] W2 = 3'd2;
  localparam logic [2:0] W4 = 3'd4;

  typedef struct packed {
    logic [2:0] left;
    logic [2:0] above;
    logic [2:0] right;
    logic [2:0] below;
  } dir_w_t;

  // Every mode distributes a total coupling of 4 across the node's inputs.
  function automatic dir_w_t node_weights(input mode_e mode, input int r, input int c,
                                          input int rows, input int cols);
    dir_w_t     w;
    logic       up_l, up_a, dn_r, dn_b;
    int         nu, nd;
    logic [2:0] ushare, dshare;
    w = '0;
    case (mode)
      MODE_PLL: w.left = W4;
      MODE_UNI: begin
        if (r == 0) begin
          w.left = W4;
        end else if (c == 0) begin
          w.above = W4;
        end else begin
          w.left  = W2;
          w.above = W2;
        end
      end
      default: begin
        up_l = (c > 0) || (r == 0 && c == 0);
        up_a = (r > 0);
        dn_r = (c < cols - 1);
        dn_b = (r < rows - 1);
        nu = 0;
        nd = 0;
        if (up_l) nu++;
        if (up_a) nu++;
        if (dn_r) nd++;
        if (dn_b) nd++;
        if (nd == 0) begin
          ushare = (nu == 2) ? W2 : W4;
          dshare = W0;
        end else begin
          ushare = (nu == 2) ? W1 : W2;
          dshare = (nd == 2) ? W1 : W2;
        end
        w.left  = up_l ? ushare : W0;
        w.above = up_a ? ushare : W0;
        w.right = dn_r ? dshare : W0;
        w.below = dn_b ? dshare : W0;
      end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mesh_lock_detect.sv
// Per-node lock detector: counts consecutive samples with |err| <= LOCK_THRESH,
// flags lock once LOCK_CYCLES are seen; any bad sample or disable clears it at once.
module mesh_lock_detect #(
  parameter int PDET_WIDTH  = 5,
  parameter int LOCK_THRESH = 2,
  parameter int LOCK_CYCLES = 512
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [PDET_WIDTH-1:0] err_i,
  output logic                  locked_o
);

  localparam int CW = $clog2(LOCK_CYCLES + 1);
  localparam logic [CW-1:0]     CNT_FULL = CW'(LOCK_CYCLES);
  localparam logic [PDET_WIDTH:0] THRESH = (PDET_WIDTH + 1)'(LOCK_THRESH);

  logic [PDET_WIDTH:0] err_ext, err_abs;
  logic                in_lock;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                locked_q, locked_d;

  // One extra bit so the most-negative input has a representable magnitude.
  always_comb begin
    err_ext = {err_i[PDET_WIDTH-1], err_i};
    err_abs = err_ext[PDET_WIDTH] ? (~err_ext + (PDET_WIDTH + 1)'(1)) : err_ext;
    in_lock = (err_abs <= THRESH);
    cnt_d   = '0;
    if (en_i && in_lock) begin
      cnt_d = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CW'(1);
    end
    locked_d = en_i && in_lock && (cnt_d == CNT_FULL);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign locked_o = locked_q;

endmodule

// File: rtl/mesh_lock_sequencer.sv
// ROWS x COLS ADPLL mesh controller: diagonal wavefront bring-up gated by per-node
// lock detection, with registered coupling weights derived from the latched mode.
module mesh_lock_sequencer
  import mesh_lock_sequencer_pkg::*;
#(
  parameter int ROWS          = 2,
  parameter int COLS          = 2,
  parameter int PDET_WIDTH    = 5,
  parameter int WEIGHT_WIDTH  = 4,
  parameter int LOCK_THRESH   = 2,
  parameter int LOCK_CYCLES   = 512,
  parameter int SETTLE_CYCLES = 4096,
  localparam int N            = ROWS * COLS,
  localparam int WAVE_W       = $clog2(ROWS + COLS)
) (
  input  logic                         fpga_clk_i,
  input  logic                         rst_n_i,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic [1:0]                   mode_i,
  input  logic [N*PDET_WIDTH-1:0]      error_i,
  output logic [N-1:0]                 node_en_o,
  output logic [N*4*WEIGHT_WIDTH-1:0]  weights_o,
  output logic [N-1:0]                 locked_o,
  output logic                         all_locked_o,
  output logic                         fail_o,
  output logic [1:0]                   state_o,
  output logic [WAVE_W-1:0]            wave_o
);

  localparam int MAX_WAVE = ROWS + COLS - 2;
  localparam int CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int WV       = 4 * WEIGHT_WIDTH;
  localparam logic [WAVE_W-1:0] WAVE_LAST = WAVE_W'(MAX_WAVE);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [WAVE_W-1:0] wave_q, wave_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              restart_q, restart_d;
  logic [N*WV-1:0]   weights_q, weights_d;
  logic [N-1:0]      wave_mask, lock_raw;
  logic              wave_done;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int I = r * COLS + c;
      localparam logic [WAVE_W-1:0] DIAG = WAVE_W'(r + c);
      dir_w_t nw;

      assign wave_mask[I] = (wave_q >= DIAG);
      assign nw = node_weights(mode_d, r, c, ROWS, COLS);
      assign weights_d[I*WV +: WV] = (state_d == ST_IDLE) ? '0 :
          {WEIGHT_WIDTH'(nw.left), WEIGHT_WIDTH'(nw.above),
           WEIGHT_WIDTH'(nw.right), WEIGHT_WIDTH'(nw.below)};

      mesh_lock_detect #(
        .PDET_WIDTH (PDET_WIDTH),
        .LOCK_THRESH(LOCK_THRESH),
        .LOCK_CYCLES(LOCK_CYCLES)
      ) u_lock (
        .clk_i   (fpga_clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (node_en_o[I]),
        .err_i   (error_i[I*PDET_WIDTH +: PDET_WIDTH]),
        .locked_o(lock_raw[I])
      );
    end
  end

  assign wave_done = ((lock_raw & wave_mask) == wave_mask);

  always_ff @(posedge fpga_clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_PLL;
      wave_q    <= '0;
      cnt_q     <= '0;
      restart_q <= 1'b0;
      weights_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      wave_q    <= wave_d;
      cnt_q     <= cnt_d;
      restart_q <= restart_d;
      weights_q <= weights_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    wave_d    = wave_q;
    cnt_d     = cnt_q;
    restart_d = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
      wave_d  = '0;
      cnt_d   = '0;
    end else if (start_i) begin
      mode_d    = mode_e'(mode_i);
      state_d   = ST_RAMP;
      cnt_d     = '0;
      wave_d    = (mode_e'(mode_i) == MODE_PLL) ? WAVE_LAST : '0;
      // A restart from a running mesh blanks every enable for one cycle.
      restart_d = (state_q != ST_IDLE);
    end else begin
      case (state_q)
        ST_IDLE, ST_LOCKED, ST_FAIL: ;
        ST_RAMP: begin
          if (!restart_q) begin
            if (wave_done) begin
              cnt_d = '0;
              if (wave_q == WAVE_LAST) state_d = ST_LOCKED;
              else                     wave_d  = wave_q + WAVE_W'(1);
            end else if (cnt_q == CNT_LAST) begin
              state_d = ST_FAIL;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    node_en_o = '0;
    if (state_q != ST_IDLE && !restart_q) node_en_o = wave_mask;
    locked_o     = lock_raw & node_en_o;
    all_locked_o = (state_q == ST_LOCKED) && (&(lock_raw & node_en_o));
    fail_o       = (state_q == ST_FAIL);
    state_o      = state_q;
    wave_o       = wave_q;
    weights_o    = weights_q;
  end

endmodule

// File: tb/tb_mesh_lock_sequencer.sv
// Directed bench: 2x2 mesh with short lock/settle windows plus a 3x4 instance for weight tables.
module tb_mesh_lock_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort;
  logic [1:0]  mode;
  logic [19:0] err;
  logic [3:0]  node_en, locked;
  logic [63:0] weights;
  logic        all_locked, fail;
  logic [1:0]  state, wave;

  logic         start2;
  logic [1:0]   mode2;
  logic [59:0]  err2;
  logic [11:0]  en2, lk2;
  logic [191:0] w2;
  logic         al2, f2;
  logic [1:0]   st2;
  logic [2:0]   wv2;

  int errors = 0;
  int checks = 0;

  mesh_lock_sequencer #(
    .ROWS(2), .COLS(2), .PDET_WIDTH(5), .WEIGHT_WIDTH(4),
    .LOCK_THRESH(2), .LOCK_CYCLES(8), .SETTLE_CYCLES(64)
  ) dut (
    .fpga_clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
    .mode_i(mode), .error_i(err), .node_en_o(node_en), .weights_o(weights),
    .locked_o(locked), .all_locked_o(all_locked), .fail_o(fail),
    .state_o(state), .wave_o(wave)
  );

  mesh_lock_sequencer #(
    .ROWS(3), .COLS(4), .PDET_WIDTH(5), .WEIGHT_WIDTH(4),
    .LOCK_THRESH(2), .LOCK_CYCLES(8), .SETTLE_CYCLES(64)
  ) dut2 (
    .fpga_clk_i(clk), .rst_n_i(rst_n), .start_i(start2), .abort_i(1'b0),
    .mode_i(mode2), .error_i(err2), .node_en_o(en2), .weights_o(w2),
    .locked_o(lk2), .all_locked_o(al2), .fail_o(f2),
    .state_o(st2), .wave_o(wv2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] nw;
    logic [63:0] sum;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; err = '0;
    start2 = 1'b0; mode2 = 2'd0; err2 = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Reset in the middle of a ramp
    mode = 2'd2; start = 1'b1; tick(1); start = 1'b0;
    tick(3);
    chk("pre_rst_state", state, 2'd1);
    rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);
    chk("rst_state", state, 2'd0);
    chk("rst_en", node_en, 4'b0000);
    chk("rst_weights", weights, 64'h0);
    chk("rst_locked", locked, 4'b0000);
    chk("rst_all_locked", all_locked, 1'b0);
    chk("rst_fail", fail, 1'b0);
    chk("rst_wave", wave, 2'd0);
    tick(2);
    chk("rst_weights_hold", weights, 64'h0);

    // Network mode wavefront
    mode = 2'd2; start = 1'b1; tick(1); start = 1'b0;
    chk("net_state", state, 2'd1);
    chk("net_wave0", wave, 2'd0);
    chk("net_en0", node_en, 4'b0001);
    chk("net_weights", weights, 64'h2200_0220_2002_2011);
    tick(8);
    chk("net_lock0", locked, 4'b0001);
    chk("net_wave0_hold", wave, 2'd0);
    tick(1);
    chk("net_wave1", wave, 2'd1);
    chk("net_en1", node_en, 4'b0111);
    tick(8);
    chk("net_lock1", locked, 4'b0111);
    tick(1);
    chk("net_wave2", wave, 2'd2);
    chk("net_en2", node_en, 4'b1111);
    tick(8);
    chk("net_ramp_late", state, 2'd1);
    chk("net_lock2", locked, 4'b1111);
    tick(1);
    chk("net_locked_state", state, 2'd2);
    chk("net_all_locked", all_locked, 1'b1);

    // Transient lock loss on node (0,1)
    err[9:5] = 5'b10000;
    tick(1);
    chk("loss_locked", locked, 4'b1101);
    chk("loss_all_locked", all_locked, 1'b0);
    chk("loss_state", state, 2'd2);
    err[9:5] = 5'd0;
    tick(7);
    chk("relock_early", locked, 4'b1101);
    tick(1);
    chk("relock", locked, 4'b1111);
    chk("relock_all", all_locked, 1'b1);

    // Restart while LOCKED blanks enables for one cycle
    start = 1'b1; tick(1); start = 1'b0;
    chk("restart_state", state, 2'd1);
    chk("restart_en_blank", node_en, 4'b0000);
    chk("restart_wave", wave, 2'd0);
    chk("restart_locked", locked, 4'b0000);
    tick(1);
    chk("restart_en", node_en, 4'b0001);

    // Abort beats start
    start = 1'b1; abort = 1'b1; tick(1); start = 1'b0; abort = 1'b0;
    chk("abort_state", state, 2'd0);
    chk("abort_en", node_en, 4'b0000);
    chk("abort_weights", weights, 64'h0);
    chk("abort_locked", locked, 4'b0000);

    // PLL mode: whole mesh at once
    mode = 2'd0; start = 1'b1; tick(1); start = 1'b0;
    chk("pll_en", node_en, 4'b1111);
    chk("pll_wave", wave, 2'd2);
    chk("pll_weights", weights, 64'h4000_4000_4000_4000);
    tick(8);
    chk("pll_ramp", state, 2'd1);
    chk("pll_lock", locked, 4'b1111);
    tick(1);
    chk("pll_locked_state", state, 2'd2);
    mode = 2'd1; tick(1);
    chk("mode_ignored", weights, 64'h4000_4000_4000_4000);

    // Node (1,1) never locks -> timeout in wave 2
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("abort2_state", state, 2'd0);
    mode = 2'd2; err[19:15] = 5'd3;
    start = 1'b1; tick(1); start = 1'b0;
    tick(81);
    chk("to_pre_state", state, 2'd1);
    chk("to_pre_wave", wave, 2'd2);
    chk("to_pre_fail", fail, 1'b0);
    tick(1);
    chk("to_state", state, 2'd3);
    chk("to_fail", fail, 1'b1);
    chk("to_en", node_en, 4'b1111);
    chk("to_locked", locked, 4'b0111);
    tick(5);
    chk("to_hold", state, 2'd3);
    chk("to_en_hold", node_en, 4'b1111);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("to_abort_fail", fail, 1'b0);
    err = '0;

    // 3x4 weight tables
    mode2 = 2'd2; start2 = 1'b1; tick(1); start2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      nw  = w2[i*16 +: 16];
      sum = 64'(nw[15:12]) + 64'(nw[11:8]) + 64'(nw[7:4]) + 64'(nw[3:0]);
      chk($sformatf("net34_sum%0d", i), sum, 64'd4);
    end
    chk("net34_n0", w2[0 +: 16], 16'h2011);
    chk("net34_n3", w2[3*16 +: 16], 16'h2002);
    chk("net34_n4", w2[4*16 +: 16], 16'h0211);
    chk("net34_n5", w2[5*16 +: 16], 16'h1111);
    chk("net34_n11", w2[11*16 +: 16], 16'h2200);
    mode2 = 2'd1; start2 = 1'b1; tick(1); start2 = 1'b0;
    chk("uni34_n0", w2[0 +: 16], 16'h4000);
    chk("uni34_n2", w2[2*16 +: 16], 16'h4000);
    chk("uni34_n4", w2[4*16 +: 16], 16'h0400);
    chk("uni34_n8", w2[8*16 +: 16], 16'h0400);
    chk("uni34_n5", w2[5*16 +: 16], 16'h2200);
    chk("uni34_n11", w2[11*16 +: 16], 16'h2200);
    mode2 = 2'd3; start2 = 1'b1; tick(1); start2 = 1'b0;
    chk("mode3_n0", w2[0 +: 16], 16'h2011);
    chk("mode3_n11", w2[11*16 +: 16], 16'h2200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
